// File: rtl/tstate_seq.sv
`default_nettype none
// ============================================================================
// tstate_seq : one-hot T-state sequencer (variable length, stall, step, halt)
// Rev 1.0
// ============================================================================
module tstate_seq #(
  parameter int NPHASE = 4,
  parameter int LEN_W  = 3
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              ce,
  input  logic              stall,
  input  logic              step_mode,
  input  logic              step,
  input  logic [LEN_W-1:0]  cyc_len,
  input  logic              done_early,
  input  logic              halt,
  output logic [NPHASE-1:0] state,
  output logic [LEN_W-1:0]  phase_idx,
  output logic              first,
  output logic              last,
  output logic              halted
);

  localparam logic [NPHASE-1:0] ST_IDLE  = '0;
  localparam logic [NPHASE-1:0] ST_T1    = {1'b1, {(NPHASE-1){1'b0}}};
  localparam logic [NPHASE-1:0] ST_ONE   = {{(NPHASE-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0]  C_NPHASE = LEN_W'(NPHASE);
  localparam logic [LEN_W-1:0]  C_ONE    = LEN_W'(1);

  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_sel;
  logic             step_d;
  logic             running;
  logic             illegal;
  logic             gate;
  logic             end_instr;

  // Out-of-range lengths fall back to the full cycle
  assign len_sel   = ((cyc_len == '0) || (cyc_len > C_NPHASE)) ? C_NPHASE : cyc_len;
  assign running   = (state != ST_IDLE);
  assign illegal   = running && ((state & (state - ST_ONE)) != ST_IDLE);
  assign gate      = !stall && (!step_mode || (step && !step_d));
  assign end_instr = (phase_idx == len_q) || done_early;

  assign first = state[NPHASE-1];
  assign last  = running && (phase_idx == len_q);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= ST_IDLE;
      phase_idx <= '0;
      halted    <= 1'b0;
      len_q     <= C_NPHASE;
      step_d    <= 1'b0;
    end else begin
      step_d <= step;
      if (!ce || illegal) begin
        state     <= ST_IDLE;
        phase_idx <= '0;
        halted    <= 1'b0;
      end else if (halted) begin
        state     <= ST_IDLE;
        phase_idx <= '0;
      end else if (!running) begin
        state     <= ST_T1;
        phase_idx <= C_ONE;
        len_q     <= len_sel;
      end else if (gate) begin
        if (end_instr) begin
          if (halt) begin
            state     <= ST_IDLE;
            phase_idx <= '0;
            halted    <= 1'b1;
          end else begin
            state     <= ST_T1;
            phase_idx <= C_ONE;
            len_q     <= len_sel;
          end
        end else begin
          state     <= state >> 1;
          phase_idx <= phase_idx + C_ONE;
        end
      end
    end
  end

endmodule
`default_nettype wire
